// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//   state_e  : arbiter FSM states (IDLE, GRANT, GAP)
//   N_REQ    : number of requesters
//   IDX_W    : width of a requester index
//   rr_pick  : round-robin search helper, returns {found, index}
package rr_decoder_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // First set request bit when scanning ptr, ptr+1, ... with wrap.
  // The loop runs from the farthest candidate down to ptr so the final
  // assignment is the nearest one, which avoids an early exit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   res;
    res = {(IDX_W+1){1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_decoder_3x8.sv
// decoder_3x8: 3-to-8 one-hot decoder with enable.
//   a, b, c : select, a = MSB, c = LSB
//   en      : enable; all outputs low when en = 0
//   d0..d7  : one-hot outputs, d<n> high when {a,b,c} == n and en = 1
module decoder_3x8 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic en,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);

  logic [7:0] dec;

  // One-hot decode of the select, gated by enable.
  always_comb begin
    dec = 8'h00;
    if (en) begin
      case ({a, b, c})
        3'd0:    dec = 8'h01;
        3'd1:    dec = 8'h02;
        3'd2:    dec = 8'h04;
        3'd3:    dec = 8'h08;
        3'd4:    dec = 8'h10;
        3'd5:    dec = 8'h20;
        3'd6:    dec = 8'h40;
        3'd7:    dec = 8'h80;
        default: dec = 8'h00;
      endcase
    end else begin
      dec = 8'h00;
    end
  end

  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dec;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: 8-requester round-robin arbiter driving a 3-to-8
// decoded grant. Ownership is held while the owner keeps its request high,
// bounded by MAX_HOLD cycles (0 = unbounded), with one dead cycle between
// owners.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request vector, bit i = requester i
//   sel_a/b/c : registered winner index (a = MSB)
//   sel_en  : registered, high while a grant is active
//   gnt     : one-hot grant decoded from sel_* and sel_en
//   busy    : high in GRANT (same as sel_en)
//   timeout : one-cycle pulse during the gap that follows a forced revoke
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic             sel_en,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [HOLD_W-1:0] hold_q;
  logic              en_q;
  logic              to_q;

  logic [IDX_W:0]    pick;
  logic              hold_expired;

  // Candidate winner from the current pointer; used in IDLE and GAP.
  always_comb begin
    pick = rr_pick(req, ptr_q);
  end

  // Ownership reaches its limit on the last allowed grant cycle.
  always_comb begin
    if (MAX_HOLD != 0) begin
      hold_expired = (hold_q == HOLD_LAST);
    end else begin
      hold_expired = 1'b0;
    end
  end

  // Arbiter FSM, rotating pointer, hold counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (pick[IDX_W]) begin
            state_q <= ST_GRANT;
            idx_q   <= pick[IDX_W-1:0];
            hold_q  <= {HOLD_W{1'b0}};
            en_q    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Release wins over timeout when both happen on the same edge.
          if (!req[idx_q]) begin
            state_q <= ST_GAP;
            en_q    <= 1'b0;
            ptr_q   <= idx_q + IDX_W'(1);
          end else if (hold_expired) begin
            state_q <= ST_GAP;
            en_q    <= 1'b0;
            to_q    <= 1'b1;
            ptr_q   <= idx_q + IDX_W'(1);
          end else begin
            // Saturate rather than wrap when the timeout is disabled.
            if (hold_q != {HOLD_W{1'b1}}) begin
              hold_q <= hold_q + HOLD_W'(1);
            end else begin
              hold_q <= hold_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sel_a   = idx_q[2];
  assign sel_b   = idx_q[1];
  assign sel_c   = idx_q[0];
  assign sel_en  = en_q;
  assign busy    = en_q;
  assign timeout = to_q;

  decoder_3x8 u_dec (
    .a  (idx_q[2]),
    .b  (idx_q[1]),
    .c  (idx_q[0]),
    .en (en_q),
    .d0 (gnt[0]),
    .d1 (gnt[1]),
    .d2 (gnt[2]),
    .d3 (gnt[3]),
    .d4 (gnt[4]),
    .d5 (gnt[5]),
    .d6 (gnt[6]),
    .d7 (gnt[7])
  );

endmodule
